histogram_builder: RTL and testbench



---
 rtl/histogram_builder_if.sv | 51 +++++
 rtl/histogram_builder.sv | 191 +++++++++++++++++++
 tb/tb_histogram_builder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_builder_if.sv
`default_nettype none
//==============================================================================
// Module      : histogram_builder_if
// Description : Pixel-stream and histogram-RAM bus for histogram_builder.
//               master : the histogram builder (accepts pixels, drives RAM).
//               slave  : the pixel source plus the dual-port histogram RAM.
//   iValid  - pixel valid this cycle           (source -> builder)
//   iPixel  - 8-bit pixel intensity / bin      (source -> builder)
//   oReady  - builder accepts a pixel          (builder -> source)
//   oAddrRd - registered RAM read address      (builder -> RAM)
//   iQ      - RAM read data, 2-cycle latency   (RAM -> builder)
//   oAddrWr - RAM write address                (builder -> RAM)
//   oDataWr - RAM write data                   (builder -> RAM)
//   oWE     - RAM write enable                 (builder -> RAM)
// Revision    : 1.0 - initial release
//==============================================================================
interface histogram_builder_if #(
  parameter int word_size = 20
);
  logic                 iValid;
  logic [7:0]           iPixel;
  logic                 oReady;
  logic [7:0]           oAddrRd;
  logic [word_size-1:0] iQ;
  logic [7:0]           oAddrWr;
  logic [word_size-1:0] oDataWr;
  logic                 oWE;

  modport master (
    input  iValid,
    input  iPixel,
    output oReady,
    output oAddrRd,
    input  iQ,
    output oAddrWr,
    output oDataWr,
    output oWE
  );

  modport slave (
    output iValid,
    output iPixel,
    input  oReady,
    input  oAddrRd,
    output iQ,
    input  oAddrWr,
    input  oDataWr,
    input  oWE
  );
endinterface
`default_nettype wire

// File: rtl/histogram_builder.sv
`default_nettype none
//==============================================================================
// Module      : histogram_builder
// Description : Builds the 256-bin intensity histogram of one frame in an
//               external dual-port RAM. On iStart all bins are cleared, then
//               num_pixels pixels are accepted and RAM[pixel] is incremented
//               (saturating) through a 3-stage read-modify-write pipeline
//               with forwarding of the two most recent writes.
// Ports       :
//   iClk    - clock
//   iRst_n  - asynchronous active-low reset
//   iStart  - one-cycle pulse, starts clear + accumulate (highest priority)
//   bus     - pixel stream and RAM bus (histogram_builder_if.master)
//   oBusy   - high while clearing, accumulating or draining
//   oDone   - one-cycle pulse when the frame histogram is complete
// Revision    : 1.0 - initial release
//==============================================================================
module histogram_builder #(
  parameter int word_size  = 20,
  parameter int num_pixels = 384000
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iStart,
  histogram_builder_if.master bus,
  output logic                oBusy,
  output logic                oDone
);

  localparam int                 c_cnt_w = 20;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(num_pixels);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [7:0]           r_clr_idx;
  logic [c_cnt_w-1:0]   r_cnt;

  // Stage 1: read address issued, waiting for RAM. Stage 2: data returns.
  logic                 r_s1_vld;
  logic [7:0]           r_s1_bin;
  logic                 r_s2_vld;
  logic [7:0]           r_s2_bin;
  logic [7:0]           r_addr_rd;

  // fw1 = write issued one cycle ago, fw2 = write issued two cycles ago.
  // Neither is visible yet in the data stage 2 receives from the RAM.
  logic                 r_fw1_vld;
  logic [7:0]           r_fw1_bin;
  logic [word_size-1:0] r_fw1_data;
  logic                 r_fw2_vld;
  logic [7:0]           r_fw2_bin;
  logic [word_size-1:0] r_fw2_data;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_last_accept;
  logic                 w_clr_we;
  logic                 w_acc_we;
  logic [word_size-1:0] w_base;
  logic [word_size-1:0] w_inc;

  // iStart wins over a simultaneous pixel, so it also masks oReady.
  assign w_ready       = (r_state == S_ACCUM) && !iStart;
  assign w_accept      = bus.iValid && w_ready;
  assign w_last_accept = w_accept && ((r_cnt + c_cnt_w'(1)) == c_last);

  // Write slot: clear writes and increment writes are mutually exclusive,
  // since entering CLEAR always flushes the increment pipeline.
  assign w_clr_we = (r_state == S_CLEAR) && !iStart;
  assign w_acc_we = r_s2_vld && !iStart;

  always_comb begin
    w_base = bus.iQ;
    if (r_fw1_vld && (r_fw1_bin == r_s2_bin)) begin
      w_base = r_fw1_data;
    end else if (r_fw2_vld && (r_fw2_bin == r_s2_bin)) begin
      w_base = r_fw2_data;
    end
  end

  assign w_inc = (&w_base) ? w_base : w_base + word_size'(1);

  assign bus.oReady  = w_ready;
  assign bus.oAddrRd = r_addr_rd;
  assign bus.oWE     = w_clr_we || w_acc_we;
  assign bus.oAddrWr = w_acc_we ? r_s2_bin : (w_clr_we ? r_clr_idx : 8'd0);
  assign bus.oDataWr = w_acc_we ? w_inc : '0;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        oBusy = 1'b1;
        if (r_clr_idx == 8'hFF) begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        oBusy = 1'b1;
        if (w_last_accept) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        oBusy = 1'b1;
        // Stage 2 finishes its write this cycle; once stage 1 is empty the
        // pipeline is empty from the next cycle on.
        if (!r_s1_vld) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        oDone       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (iStart) begin
      w_state_nxt = S_CLEAR;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_clr_idx  <= 8'd0;
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_bin   <= 8'd0;
      r_s2_vld   <= 1'b0;
      r_s2_bin   <= 8'd0;
      r_addr_rd  <= 8'd0;
      r_fw1_vld  <= 1'b0;
      r_fw1_bin  <= 8'd0;
      r_fw1_data <= '0;
      r_fw2_vld  <= 1'b0;
      r_fw2_bin  <= 8'd0;
      r_fw2_data <= '0;
    end else if (iStart) begin
      r_clr_idx <= 8'd0;
      r_cnt     <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_fw1_vld <= 1'b0;
      r_fw2_vld <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_idx <= r_clr_idx + 8'd1;
      end
      if (w_accept) begin
        r_cnt     <= r_cnt + c_cnt_w'(1);
        r_addr_rd <= bus.iPixel;
        r_s1_bin  <= bus.iPixel;
      end
      r_s1_vld   <= w_accept;
      r_s2_vld   <= r_s1_vld;
      r_s2_bin   <= r_s1_bin;
      r_fw1_vld  <= w_acc_we;
      r_fw1_bin  <= r_s2_bin;
      r_fw1_data <= w_inc;
      r_fw2_vld  <= r_fw1_vld;
      r_fw2_bin  <= r_fw1_bin;
      r_fw2_data <= r_fw1_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_histogram_builder.sv
`default_nettype none
//==============================================================================
// Module      : tb_histogram_builder
// Description : Self-checking bench for histogram_builder. Two instances:
//               a wide one (word_size 20, 8 pixels/frame) and a narrow one
//               (word_size 3, 10 pixels/frame) for saturation. Each has a
//               RAM model whose read data lags writes by two issue cycles.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_histogram_builder;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic       iRst_n;
  logic       start;
  logic       valid;
  logic [7:0] pix;
  bit         sel;
  logic       start_a, start_s, busy_a, busy_s, done_a, done_s;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] stim_q[$];

  always @(posedge iClk) cyc <= cyc + 1;

  histogram_builder_if #(.word_size(20)) bus_a ();
  histogram_builder_if #(.word_size(3))  bus_s ();

  assign start_a      = start & ~sel;
  assign start_s      = start & sel;
  assign bus_a.iValid = valid & ~sel;
  assign bus_s.iValid = valid & sel;
  assign bus_a.iPixel = pix;
  assign bus_s.iPixel = pix;

  histogram_builder #(.word_size(20), .num_pixels(8)) dut_a (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(start_a), .bus(bus_a),
    .oBusy(busy_a), .oDone(done_a)
  );
  histogram_builder #(.word_size(3), .num_pixels(10)) dut_s (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(start_s), .bus(bus_s),
    .oBusy(busy_s), .oDone(done_s)
  );

  // RAM models: writes commit one edge after issue, reads sample before
  // the same edge's commit, so iQ excludes the two most recent writes.
  logic        preload;
  logic [19:0] preload_val;
  logic [19:0] mem_a [256];
  logic [19:0] q_a, wd_a;
  logic [7:0]  wa_a;
  logic        we_a;
  logic [2:0]  mem_s [256];
  logic [2:0]  q_s, wd_s;
  logic [7:0]  wa_s;
  logic        we_s;

  always @(posedge iClk) begin
    we_a <= bus_a.oWE; wa_a <= bus_a.oAddrWr; wd_a <= bus_a.oDataWr;
    we_s <= bus_s.oWE; wa_s <= bus_s.oAddrWr; wd_s <= bus_s.oDataWr;
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= preload_val;
        mem_s[i] <= preload_val[2:0];
      end
    end else begin
      if (we_a) mem_a[wa_a] <= wd_a;
      if (we_s) mem_s[wa_s] <= wd_s;
    end
    q_a <= mem_a[bus_a.oAddrRd];
    q_s <= mem_s[bus_s.oAddrRd];
  end
  assign bus_a.iQ = q_a;
  assign bus_s.iQ = q_s;

  // Observed outputs of the instance selected by sel.
  logic        t_ready, t_we, t_done, t_busy;
  logic [7:0]  t_awr, t_ard;
  logic [19:0] t_dwr;
  assign t_ready = sel ? bus_s.oReady  : bus_a.oReady;
  assign t_we    = sel ? bus_s.oWE     : bus_a.oWE;
  assign t_done  = sel ? done_s        : done_a;
  assign t_busy  = sel ? busy_s        : busy_a;
  assign t_awr   = sel ? bus_s.oAddrWr : bus_a.oAddrWr;
  assign t_ard   = sel ? bus_s.oAddrRd : bus_a.oAddrRd;
  assign t_dwr   = sel ? {17'd0, bus_s.oDataWr} : bus_a.oDataWr;

  function automatic logic [31:0] mem_rd(input bit s, input int i);
    if (s) return {29'd0, mem_s[i]};
    return {12'd0, mem_a[i]};
  endfunction

  task automatic nxt();
    @(posedge iClk);
    #1;
  endtask

  // Runs one frame from iStart with the pixels in stim_q and reports what
  // was observed; the reference histogram is a plain count per value,
  // clipped at the bin maximum.
  task automatic do_frame(input int gap_pct, input int gap_at,
                          output int clr_len, output int clr_bad, output int lat,
                          output int done_cnt, output int bad_bins, output int first_bad);
    int          refh [256];
    int          maxv, t0, idx, last_acc;
    logic [31:0] got;
    maxv = sel ? 7 : 1048575;
    foreach (refh[i]) refh[i] = 0;
    foreach (stim_q[i]) refh[stim_q[i]] = refh[stim_q[i]] + 1;
    foreach (refh[i]) if (refh[i] > maxv) refh[i] = maxv;
    clr_len = -1; clr_bad = 0; lat = -1; done_cnt = 0;
    bad_bins = 0; first_bad = -1; last_acc = 0;
    valid = 1'b0; start = 1'b1; t0 = cyc;
    nxt();
    start = 1'b0;
    idx = 0;
    for (int k = 0; k < 300; k++) begin
      #2;
      if (t_ready === 1'b1) begin
        clr_len = cyc - t0;
        break;
      end
      if (!(t_we === 1'b1 && t_awr === idx[7:0] && t_dwr === 20'd0)) clr_bad++;
      idx++;
      nxt();
    end
    foreach (stim_q[i]) begin
      if (i == gap_at || int'($urandom_range(0, 99)) < gap_pct) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 2)) nxt();
      end
      valid = 1'b1; pix = stim_q[i]; last_acc = cyc;
      nxt();
    end
    // Keep offering pixels after the frame; none may be accepted.
    for (int k = 0; k < 20; k++) begin
      valid = 1'b1; pix = 8'($urandom);
      #2;
      if (t_done === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = cyc - last_acc;
      end
      nxt();
    end
    valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      got = mem_rd(sel, i);
      if (got !== 32'(refh[i])) begin
        bad_bins++;
        if (first_bad < 0) first_bad = i;
      end
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; start = 1'b0; valid = 1'b0; pix = 8'd0; sel = 1'b0;
    preload = 1'b0; preload_val = 20'd0;
    repeat (3) nxt();
    for (int p = 0; p < 2; p++) begin
      #2;
      n_total++; if (t_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", t_ready); else n_pass++;
      n_total++; if (t_we !== 1'b0) $display("FAIL reset_we: got %b want 0", t_we); else n_pass++;
      n_total++; if (t_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", t_busy); else n_pass++;
      n_total++; if (t_done !== 1'b0) $display("FAIL reset_done: got %b want 0", t_done); else n_pass++;
      n_total++; if (t_awr !== 8'd0) $display("FAIL reset_addr_wr: got %0h want 0", t_awr); else n_pass++;
      n_total++; if (t_dwr !== 20'd0) $display("FAIL reset_data_wr: got %0h want 0", t_dwr); else n_pass++;
      n_total++; if (t_ard !== 8'd0) $display("FAIL reset_addr_rd: got %0h want 0", t_ard); else n_pass++;
      iRst_n = 1'b1;
      nxt();
    end
  endtask

  task automatic test_clear();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b0;
    preload_val = 20'hABCDE; preload = 1'b1; nxt(); preload = 1'b0;
    stim_q.delete();
    repeat (8) stim_q.push_back(8'($urandom));
    do_frame(0, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (cl !== 257) $display("FAIL clear_len: ready after %0d cycles want 257", cl); else n_pass++;
    n_total++; if (cb !== 0) $display("FAIL clear_writes: %0d bad clear cycles want 0", cb); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL clear_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL clear_done: %0d pulses want 1", dc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b0;
    stim_q.delete();
    repeat (8) stim_q.push_back(8'd7);
    do_frame(0, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (mem_rd(0, 7) !== 32'd8) $display("FAIL b2b_bin7: got %0d want 8", mem_rd(0, 7)); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL b2b_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL b2b_done: %0d pulses want 1", dc); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL b2b_latency: done %0d cycles after last accept want 3", lat); else n_pass++;
  endtask

  task automatic test_mixed();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b0;
    stim_q = '{8'd3, 8'd5, 8'd3, 8'd3, 8'd5, 8'd9, 8'd5, 8'd3};
    do_frame(0, 2, cl, cb, lat, dc, bb, fb);
    n_total++; if (mem_rd(0, 3) !== 32'd4) $display("FAIL mixed_bin3: got %0d want 4", mem_rd(0, 3)); else n_pass++;
    n_total++; if (mem_rd(0, 5) !== 32'd3) $display("FAIL mixed_bin5: got %0d want 3", mem_rd(0, 5)); else n_pass++;
    n_total++; if (mem_rd(0, 9) !== 32'd1) $display("FAIL mixed_bin9: got %0d want 1", mem_rd(0, 9)); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL mixed_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
  endtask

  task automatic test_random();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b0;
    for (int f = 0; f < 6; f++) begin
      stim_q.delete();
      repeat (8) stim_q.push_back(8'($urandom_range(0, 3)));
      do_frame(30, -1, cl, cb, lat, dc, bb, fb);
      n_total++; if (bb !== 0) $display("FAIL rand_bins f%0d: %0d bad bins (first %0d) want 0", f, bb, fb); else n_pass++;
      n_total++; if (dc !== 1) $display("FAIL rand_done f%0d: %0d pulses want 1", f, dc); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL rand_latency f%0d: got %0d want 3", f, lat); else n_pass++;
    end
  endtask

  task automatic test_restart();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b0; valid = 1'b0;
    start = 1'b1; nxt(); start = 1'b0;
    #2;
    for (int k = 0; k < 300 && t_ready !== 1'b1; k++) begin
      nxt(); #2;
    end
    n_total++; if (t_ready !== 1'b1) $display("FAIL restart_ready: got %b want 1", t_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; pix = (i == 2) ? 8'd201 : 8'd200;
      nxt();
    end
    valid = 1'b0;
    stim_q.delete();
    repeat (8) stim_q.push_back(8'($urandom_range(198, 202)));
    do_frame(20, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (cb !== 0) $display("FAIL restart_clear: %0d bad clear cycles want 0", cb); else n_pass++;
    n_total++; if (cl !== 257) $display("FAIL restart_clear_len: got %0d want 257", cl); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL restart_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL restart_done: %0d pulses want 1", dc); else n_pass++;
  endtask

  task automatic test_saturation();
    int cl, cb, lat, dc, bb, fb;
    sel = 1'b1;
    stim_q.delete();
    repeat (10) stim_q.push_back(8'd0);
    do_frame(0, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (mem_rd(1, 0) !== 32'd7) $display("FAIL sat_bin0: got %0d want 7", mem_rd(1, 0)); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL sat_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL sat_done: %0d pulses want 1", dc); else n_pass++;
    stim_q.delete();
    repeat (10) stim_q.push_back(8'($urandom_range(0, 1)));
    do_frame(25, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (bb !== 0) $display("FAIL sat_rand_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int cl, cb, lat, dc, bb, fb, n_done, n_busy;
    sel = 1'b0; valid = 1'b0;
    start = 1'b1; nxt(); start = 1'b0;
    repeat (50) nxt();
    #2;
    iRst_n = 1'b0;
    #1;
    n_total++; if (t_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", t_busy); else n_pass++;
    n_total++; if (t_we !== 1'b0) $display("FAIL rst_mid_we: got %b want 0", t_we); else n_pass++;
    n_total++; if (t_awr !== 8'd0) $display("FAIL rst_mid_addr_wr: got %0h want 0", t_awr); else n_pass++;
    n_total++; if (t_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", t_ready); else n_pass++;
    n_total++; if (t_ard !== 8'd0) $display("FAIL rst_mid_addr_rd: got %0h want 0", t_ard); else n_pass++;
    nxt(); nxt();
    iRst_n = 1'b1;
    n_done = 0; n_busy = 0;
    for (int k = 0; k < 300; k++) begin
      #2;
      if (t_done !== 1'b0) n_done++;
      if (t_busy !== 1'b0) n_busy++;
      nxt();
    end
    n_total++; if (n_done !== 0) $display("FAIL rst_mid_no_done: %0d done cycles want 0", n_done); else n_pass++;
    n_total++; if (n_busy !== 0) $display("FAIL rst_mid_idle: %0d busy cycles want 0", n_busy); else n_pass++;
    stim_q.delete();
    repeat (8) stim_q.push_back(8'($urandom_range(10, 13)));
    do_frame(20, -1, cl, cb, lat, dc, bb, fb);
    n_total++; if (bb !== 0) $display("FAIL rst_mid_bins: %0d bad bins (first %0d) want 0", bb, fb); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL rst_mid_done: %0d pulses want 1", dc); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clear();
    test_back_to_back();
    test_mixed();
    test_random();
    test_restart();
    test_saturation();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
